// File: rtl/m_mem_arbiter.sv
// Arbiter that lets the data stage, instruction fetch and debug loader share one
// single-port synchronous RAM. It uses fixed priority with anti-starvation aging and a G lock.
module m_mem_arbiter #(
   parameter int AW         = 11,
   parameter int DW         = 32,
   parameter int STARVE_MAX = 4
) (
   input  logic          w_clk,
   input  logic          w_rst,
   input  logic          w_d_req,
   input  logic          w_d_we,
   input  logic [AW-1:0] w_d_addr,
   input  logic [DW-1:0] w_d_din,
   input  logic          w_i_req,
   input  logic [AW-1:0] w_i_addr,
   input  logic          w_g_req,
   input  logic          w_g_we,
   input  logic [AW-1:0] w_g_addr,
   input  logic [DW-1:0] w_g_din,
   input  logic          w_g_lock,
   output logic          w_gnt_d,
   output logic          w_gnt_i,
   output logic          w_gnt_g,
   output logic          r_rvalid,
   output logic [1:0]    r_rsrc,
   output logic [DW-1:0] r_rdata,
   output logic          r_stall_if,
   output logic          r_locked
);

   // state      | meaning
   // ST_NORMAL  | priority arbitration with aging
   // ST_LOCK_PEND | G only; one cycle to drain in-flight reads
   // ST_LOCKED  | G owns the RAM; I age frozen
   typedef enum logic [1:0] {ST_NORMAL, ST_LOCK_PEND, ST_LOCKED} state_t;

   localparam logic [2:0] AGE_LIM = 3'(STARVE_MAX);

   state_t        state;
   logic [2:0]    age_i;
   logic [2:0]    age_g;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [1:0]    ram_src;
   logic          ram_en;
   logic          ram_wr;
   logic          ram_rd;

   function automatic logic [2:0] age_next(input logic req, input logic gnt, input logic [2:0] age);
      if (!req || gnt)
         return 3'd0;
      else if (age != 3'd7)
         return age + 3'd1;
      else
         return age;
   endfunction

   always_comb begin
      w_gnt_d = 1'b0;
      w_gnt_i = 1'b0;
      w_gnt_g = 1'b0;
      if (state != ST_NORMAL)
         w_gnt_g = w_g_req;
      else if (w_i_req && (age_i >= AGE_LIM))
         w_gnt_i = 1'b1;
      else if (w_g_req && (age_g >= AGE_LIM))
         w_gnt_g = 1'b1;
      else if (w_d_req)
         w_gnt_d = 1'b1;
      else if (w_i_req)
         w_gnt_i = 1'b1;
      else
         w_gnt_g = w_g_req;
   end

   always_comb begin
      ram_addr = w_d_addr;
      ram_din  = w_d_din;
      ram_we   = w_d_we;
      ram_src  = 2'd0;
      if (w_gnt_i) begin
         ram_addr = w_i_addr;
         ram_we   = 1'b0;
         ram_src  = 2'd1;
      end else if (w_gnt_g) begin
         ram_addr = w_g_addr;
         ram_din  = w_g_din;
         ram_we   = w_g_we;
         ram_src  = 2'd2;
      end
   end

   assign ram_en = w_gnt_d | w_gnt_i | w_gnt_g;
   // a write that coincides with reset must not corrupt memory
   assign ram_wr = ram_en & ram_we & ~w_rst;
   assign ram_rd = ram_en & ~ram_we;

   always_ff @(posedge w_clk) begin
      if (ram_wr)
         mem[ram_addr] <= ram_din;
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         r_rvalid   <= 1'b0;
         r_rsrc     <= 2'd0;
         r_rdata    <= '0;
         r_stall_if <= 1'b0;
      end else begin
         r_rvalid   <= ram_rd;
         r_stall_if <= w_i_req & ~w_gnt_i;
         if (ram_rd) begin
            r_rsrc  <= ram_src;
            r_rdata <= mem[ram_addr];
         end
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         state    <= ST_NORMAL;
         r_locked <= 1'b0;
         age_i    <= 3'd0;
         age_g    <= 3'd0;
      end else begin
         age_g <= age_next(w_g_req, w_gnt_g, age_g);
         if (state != ST_LOCKED)
            age_i <= age_next(w_i_req, w_gnt_i, age_i);
         case (state)
            ST_NORMAL: begin
               if (w_g_lock)
                  state <= ST_LOCK_PEND;
            end
            ST_LOCK_PEND: begin
               if (w_g_lock) begin
                  state    <= ST_LOCKED;
                  r_locked <= 1'b1;
               end else begin
                  state <= ST_NORMAL;
               end
            end
            ST_LOCKED: begin
               if (!w_g_lock) begin
                  state    <= ST_NORMAL;
                  r_locked <= 1'b0;
               end
            end
            default: begin
               state    <= ST_NORMAL;
               r_locked <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_m_mem_arbiter.sv
// Bench for m_mem_arbiter: directed vector tables, then random traffic against a
// reference model built from the arbitration rules.
module tb_m_mem_arbiter;
   localparam int STARVE = 4;
   localparam logic N = 1'b0, Y = 1'b1;
   localparam logic [31:0] Z = 32'h0, A = 32'h12345678, B = 32'hDEADBEEF;
   localparam logic [31:0] C = 32'hA5A50001, E = 32'hCAFEF00D, F = 32'h0BADCAFE;

   logic        w_clk = 1'b0;
   logic        w_rst, w_d_req, w_d_we, w_i_req, w_g_req, w_g_we, w_g_lock;
   logic [10:0] w_d_addr, w_i_addr, w_g_addr;
   logic [31:0] w_d_din, w_g_din;
   logic        w_gnt_d, w_gnt_i, w_gnt_g, r_rvalid, r_stall_if, r_locked;
   logic [1:0]  r_rsrc;
   logic [31:0] r_rdata;

   int n_pass = 0;
   int n_chk  = 0;

   m_mem_arbiter dut (
      .w_clk(w_clk), .w_rst(w_rst),
      .w_d_req(w_d_req), .w_d_we(w_d_we), .w_d_addr(w_d_addr), .w_d_din(w_d_din),
      .w_i_req(w_i_req), .w_i_addr(w_i_addr),
      .w_g_req(w_g_req), .w_g_we(w_g_we), .w_g_addr(w_g_addr), .w_g_din(w_g_din),
      .w_g_lock(w_g_lock),
      .w_gnt_d(w_gnt_d), .w_gnt_i(w_gnt_i), .w_gnt_g(w_gnt_g),
      .r_rvalid(r_rvalid), .r_rsrc(r_rsrc), .r_rdata(r_rdata),
      .r_stall_if(r_stall_if), .r_locked(r_locked)
   );

   always #5 w_clk = ~w_clk;

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish within 1000000 time units");
      $fatal(1, "timeout");
   end

   // Inputs are for the current cycle; expected grant is combinational, the other
   // expected outputs are the registered results of the previous cycle.
   typedef struct {
      logic        rst;
      logic [2:0]  req;      // {d, i, g}
      logic        d_we;
      logic [10:0] d_addr;
      logic [31:0] d_din;
      logic [10:0] i_addr;
      logic        g_we;
      logic [10:0] g_addr;
      logic [31:0] g_din;
      logic        g_lock;
      logic [2:0]  gnt;      // {d, i, g}
      logic        rvalid;
      logic [1:0]  rsrc;
      logic [31:0] rdata;
      logic        stall;
      logic        locked;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      w_rst    = v.rst;
      w_d_req  = v.req[2]; w_d_we = v.d_we; w_d_addr = v.d_addr; w_d_din = v.d_din;
      w_i_req  = v.req[1]; w_i_addr = v.i_addr;
      w_g_req  = v.req[0]; w_g_we = v.g_we; w_g_addr = v.g_addr; w_g_din = v.g_din;
      w_g_lock = v.g_lock;
      @(negedge w_clk);
      check({tag, ".gnt"},    32'({w_gnt_d, w_gnt_i, w_gnt_g}), 32'(v.gnt));
      check({tag, ".rvalid"}, 32'(r_rvalid), 32'(v.rvalid));
      check({tag, ".rdata"},  r_rdata, v.rdata);
      check({tag, ".stall"},  32'(r_stall_if), 32'(v.stall));
      check({tag, ".locked"}, 32'(r_locked), 32'(v.locked));
      if (v.rvalid)
         check({tag, ".rsrc"}, 32'(r_rsrc), 32'(v.rsrc));
      @(posedge w_clk);
      #1;
   endtask

   function automatic logic [10:0] pick_addr();
      logic [10:0] a;
      a = 11'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
         a = a | 11'h7F8;
      return a;
   endfunction

   // reference model state
   int          wait_i, wait_g;
   bit          m_pend, m_lock;
   bit          e_rvalid, e_known, e_stall;
   logic [1:0]  e_rsrc;
   logic [31:0] e_rdata;
   logic [31:0] mmem [int];

   initial begin
      vec_t tbl[$];
      vec_t lock_seq[$];
      vec_t rst_seq[$];
      bit   d_hold, g_hold;
      int   win;

      // reset, single read, fetch aging, top-address write/read, write-then-read, G aging
      tbl.push_back('{Y,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,N,2'd0,Z,N,N});
      tbl.push_back('{N,3'b001,N,11'h000,Z,11'h000,Y,11'h010,A,N, 3'b001,N,2'd0,Z,N,N});
      tbl.push_back('{N,3'b100,N,11'h010,Z,11'h000,N,11'h000,Z,N, 3'b100,N,2'd0,Z,N,N});
      tbl.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd0,A,N,N});
      tbl.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,N,2'd0,A,N,N});
      tbl.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,Y,2'd0,A,Y,N});
      tbl.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,Y,2'd0,A,Y,N});
      tbl.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,Y,2'd0,A,Y,N});
      tbl.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b010,Y,2'd0,A,Y,N});
      tbl.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,Y,2'd1,A,N,N});
      tbl.push_back('{N,3'b001,N,11'h000,Z,11'h000,Y,11'h7FF,B,N, 3'b001,Y,2'd0,A,Y,N});
      tbl.push_back('{N,3'b010,N,11'h000,Z,11'h7FF,N,11'h000,Z,N, 3'b010,N,2'd0,A,N,N});
      tbl.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd1,B,N,N});
      tbl.push_back('{N,3'b001,N,11'h000,Z,11'h000,Y,11'h000,C,N, 3'b001,N,2'd0,B,N,N});
      tbl.push_back('{N,3'b100,N,11'h7FF,Z,11'h000,N,11'h000,Z,N, 3'b100,N,2'd0,B,N,N});
      tbl.push_back('{N,3'b100,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b100,Y,2'd0,B,N,N});
      tbl.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd0,C,N,N});
      tbl.push_back('{N,3'b100,Y,11'h020,E,11'h000,N,11'h000,Z,N, 3'b100,N,2'd0,C,N,N});
      tbl.push_back('{N,3'b100,N,11'h020,Z,11'h000,N,11'h000,Z,N, 3'b100,N,2'd0,C,N,N});
      tbl.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd0,E,N,N});
      tbl.push_back('{N,3'b101,N,11'h010,Z,11'h000,N,11'h000,Z,N, 3'b100,N,2'd0,E,N,N});
      tbl.push_back('{N,3'b101,N,11'h010,Z,11'h000,N,11'h000,Z,N, 3'b100,Y,2'd0,A,N,N});
      tbl.push_back('{N,3'b101,N,11'h010,Z,11'h000,N,11'h000,Z,N, 3'b100,Y,2'd0,A,N,N});
      tbl.push_back('{N,3'b101,N,11'h010,Z,11'h000,N,11'h000,Z,N, 3'b100,Y,2'd0,A,N,N});
      tbl.push_back('{N,3'b101,N,11'h010,Z,11'h000,N,11'h000,Z,N, 3'b001,Y,2'd0,A,N,N});
      tbl.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd2,C,N,N});

      // lock entry, exclusive G burst, release; I age must not advance while locked
      lock_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,Y, 3'b100,N,2'd0,C,N,N});
      lock_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,Y, 3'b000,Y,2'd0,A,Y,N});
      lock_seq.push_back('{N,3'b111,N,11'h010,Z,11'h010,Y,11'h030,F,Y, 3'b001,N,2'd0,A,Y,Y});
      lock_seq.push_back('{N,3'b111,N,11'h010,Z,11'h010,N,11'h030,Z,Y, 3'b001,N,2'd0,A,Y,Y});
      lock_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b000,Y,2'd2,F,Y,Y});
      lock_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,N,2'd0,F,Y,N});
      lock_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,Y,2'd0,A,Y,N});
      lock_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b010,Y,2'd0,A,Y,N});
      lock_seq.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd1,A,N,N});

      // reset after an I read, write during reset suppressed, reset out of LOCK_PEND
      rst_seq.push_back('{N,3'b010,N,11'h000,Z,11'h7FF,N,11'h000,Z,N, 3'b010,N,2'd0,A,N,N});
      rst_seq.push_back('{Y,3'b100,Y,11'h7FF,32'h11111111,11'h000,N,11'h000,Z,N, 3'b100,Y,2'd1,B,N,N});
      rst_seq.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,N,2'd0,Z,N,N});
      rst_seq.push_back('{N,3'b100,N,11'h7FF,Z,11'h000,N,11'h000,Z,N, 3'b100,N,2'd0,Z,N,N});
      rst_seq.push_back('{N,3'b000,N,11'h000,Z,11'h000,N,11'h000,Z,N, 3'b000,Y,2'd0,B,N,N});
      rst_seq.push_back('{N,3'b010,N,11'h000,Z,11'h7FF,N,11'h000,Z,Y, 3'b010,N,2'd0,B,N,N});
      rst_seq.push_back('{Y,3'b010,N,11'h000,Z,11'h7FF,N,11'h000,Z,Y, 3'b000,Y,2'd1,B,N,N});
      rst_seq.push_back('{N,3'b110,N,11'h010,Z,11'h010,N,11'h000,Z,N, 3'b100,N,2'd0,Z,N,N});

      w_rst = 1'b1; w_d_req = 1'b0; w_d_we = 1'b0; w_d_addr = '0; w_d_din = '0;
      w_i_req = 1'b0; w_i_addr = '0; w_g_req = 1'b0; w_g_we = 1'b0; w_g_addr = '0;
      w_g_din = '0; w_g_lock = 1'b0;
      @(posedge w_clk);
      #1;

      foreach (tbl[k])      run_vec(tbl[k], $sformatf("tbl%0d", k));
      foreach (lock_seq[k]) run_vec(lock_seq[k], $sformatf("lock%0d", k));
      foreach (rst_seq[k])  run_vec(rst_seq[k], $sformatf("rst%0d", k));

      // random traffic; start from a reset so the model knows the register state
      w_rst = 1'b1; w_d_req = 1'b0; w_i_req = 1'b0; w_g_req = 1'b0; w_g_lock = 1'b0;
      @(posedge w_clk);
      #1;
      wait_i = 0; wait_g = 0; m_pend = 0; m_lock = 0;
      e_rvalid = 0; e_rsrc = 2'd0; e_rdata = '0; e_known = 1; e_stall = 0;
      d_hold = 0; g_hold = 0;

      for (int c = 0; c < 4000; c++) begin
         w_rst = ($urandom_range(0, 299) == 0);
         if (!d_hold) begin
            w_d_req  = ($urandom_range(0, 1) == 1);
            w_d_we   = ($urandom_range(0, 3) == 0);
            w_d_addr = pick_addr();
            w_d_din  = $urandom;
         end
         w_i_req  = ($urandom_range(0, 3) != 0);
         w_i_addr = pick_addr();
         if (!g_hold) begin
            w_g_req  = ($urandom_range(0, 2) == 0);
            w_g_we   = ($urandom_range(0, 1) == 1);
            w_g_addr = pick_addr();
            w_g_din  = $urandom;
         end
         if ($urandom_range(0, 24) == 0)
            w_g_lock = ~w_g_lock;

         // winner: 0 none, 1 D, 2 I, 3 G
         if (m_pend || m_lock)                       win = w_g_req ? 3 : 0;
         else if (w_i_req && wait_i >= STARVE)       win = 2;
         else if (w_g_req && wait_g >= STARVE)       win = 3;
         else if (w_d_req)                           win = 1;
         else if (w_i_req)                           win = 2;
         else if (w_g_req)                           win = 3;
         else                                        win = 0;

         @(negedge w_clk);
         check("rnd.gnt", 32'({w_gnt_d, w_gnt_i, w_gnt_g}),
               32'({win == 1, win == 2, win == 3}));
         check("rnd.rvalid", 32'(r_rvalid), 32'(e_rvalid));
         check("rnd.stall", 32'(r_stall_if), 32'(e_stall));
         check("rnd.locked", 32'(r_locked), 32'(m_lock));
         if (e_rvalid)
            check("rnd.rsrc", 32'(r_rsrc), 32'(e_rsrc));
         if (e_known)
            check("rnd.rdata", r_rdata, e_rdata);

         if (w_rst) begin
            wait_i = 0; wait_g = 0; m_pend = 0; m_lock = 0;
            e_rvalid = 0; e_rsrc = 2'd0; e_rdata = '0; e_known = 1; e_stall = 0;
         end else begin
            if (!m_lock)
               wait_i = (w_i_req && win != 2) ? wait_i + 1 : 0;
            wait_g  = (w_g_req && win != 3) ? wait_g + 1 : 0;
            e_stall = w_i_req && (win != 2);
            e_rvalid = 0;
            if (win == 1 && w_d_we)       mmem[int'(w_d_addr)] = w_d_din;
            else if (win == 3 && w_g_we)  mmem[int'(w_g_addr)] = w_g_din;
            else if (win != 0) begin
               int a;
               a = (win == 1) ? int'(w_d_addr) : (win == 2) ? int'(w_i_addr) : int'(w_g_addr);
               e_rvalid = 1;
               e_rsrc   = 2'(win - 1);
               e_known  = mmem.exists(a);
               if (e_known)
                  e_rdata = mmem[a];
            end
            if (m_lock)      m_lock = w_g_lock;
            else if (m_pend) begin m_pend = 0; m_lock = w_g_lock; end
            else             m_pend = w_g_lock;
         end
         d_hold = w_d_req && (win != 1);
         g_hold = w_g_req && (win != 3);
         @(posedge w_clk);
         #1;
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
